// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NUM_REQ byte producers.
// Only one frame is in flight at a time. The grant is taken in IDLE when some
// requester is valid and the transmitter is idle. The arbiter then holds the
// word and waits in WAIT_DONE for tx_done.
//
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts WAIT_DONE after TIMEOUT_CYCLES cycles and
//   pulses timeout_err. When undefined, timeout_err is held at 0.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_valid    per-requester word-available flags
//   req_data     requester i word at [i*DATA_BITS +: DATA_BITS]
//   req_ready    one-hot, 1-cycle ack of the accepted word
//   grant_id     last/current granted requester
//   arb_busy     high while a frame is owned
//   tx_start     1-cycle start pulse to uart_tx
//   tx_data      word to uart_tx, held for the whole frame
//   tx_busy      uart_tx busy
//   tx_done      uart_tx end-of-frame pulse
//   timeout_err  1-cycle watchdog expiry pulse
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           arb_busy,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic                           timeout_err
);
  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         pick, sel, gid_d;
  logic                   found;
  int                     idx;
  logic [NUM_REQ-1:0]     rdy_d;
  logic                   start_d, busy_d, tmo_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   expire;

  // First valid requester at or above the pointer, wrapping at NUM_REQ-1.
  // The wrap is explicit so that NUM_REQ values that are not powers of 2
  // never index past the last requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDW'(idx);
      if (!found && req_valid[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  // The counter is held at 0 in IDLE, so it starts from 0 on every WAIT_DONE entry.
  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (state_q == IDLE) cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rdy_d   = '0;
    start_d = 1'b0;
    data_d  = tx_data;
    gid_d   = grant_id;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // tx_busy covers a uart_tx that is still draining its stop bit.
        if (found && !tx_busy) begin
          data_d  = req_data[pick*DATA_BITS +: DATA_BITS];
          gid_d   = pick;
          rdy_d   = NUM_REQ'(1) << pick;
          start_d = 1'b1;
          ptr_d   = (pick == IDW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // If tx_done arrives in the expiry cycle, it wins and no error is raised.
        if (tx_done) state_d = IDLE;
        else if (expire) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WAIT_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      req_ready   <= rdy_d;
      tx_start    <= start_d;
      tx_data     <= data_d;
      grant_id    <= gid_d;
      arb_busy    <= busy_d;
      timeout_err <= tmo_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [1:0]      grant_id;
  logic            arb_busy, tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy, tx_done, timeout_err;

  typedef struct packed {
    logic [1:0]    gid;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   tmo_seen = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .arb_busy(arb_busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_done(tx_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every start pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_data",  tx_data,   e.data);
        chk("sb_gid",   grant_id,  e.gid);
        chk("sb_ready", req_ready, 4'b0001 << e.gid);
        chk("sb_busy",  arb_busy,  1);
      end
    end
    if (timeout_err) tmo_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string nm);
    int k;
    k = 0;
    while (!tx_start && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk(nm, tx_start, 1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    cyc(1);
    tx_done = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"}, req_ready, 0);
    chk({nm, "_start"}, tx_start, 0);
    chk({nm, "_data"},  tx_data, 0);
    chk({nm, "_gid"},   grant_id, 0);
    chk({nm, "_busy"},  arb_busy, 0);
    chk({nm, "_tmo"},   timeout_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    tx_busy = 1'b0;
    tx_done = 1'b0;
    cyc(3);
    chk_reset("rst");
    rst = 1'b0;
    req_valid = '0;
    cyc(2);
    chk("idle_no_start", tx_start, 0);

    // Single requester 2.
    req_data[2*DW +: DW] = 8'hA5;
    req_valid = 4'b0100;
    exp_q.push_back('{gid: 2'd2, data: 8'hA5});
    cyc(1);
    chk("t1_start", tx_start, 1);
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_gid", grant_id, 2);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_busy", arb_busy, 1);
    req_valid = '0;
    cyc(4);
    chk("t1_one_start", tx_start, 0);
    chk("t1_ready_low", req_ready, 0);
    chk("t1_data_held", tx_data, 8'hA5);
    chk("t1_still_busy", arb_busy, 1);
    pulse_done();
    chk("t1_idle", arb_busy, 0);
    chk("t1_gid_held", grant_id, 2);

    // A spurious tx_done in IDLE has no effect.
    pulse_done();
    cyc(2);
    chk("spurious_busy", arb_busy, 0);
    chk("spurious_start", tx_start, 0);

    // tx_busy blocks the grant; the pointer is 3, so requester 0 wins by wrap.
    tx_busy = 1'b1;
    req_data[0 +: DW] = 8'h3C;
    req_valid = 4'b0001;
    repeat (20) begin
      cyc(1);
      chk("t4_no_start", tx_start, 0);
      chk("t4_no_ready", req_ready, 0);
    end
    exp_q.push_back('{gid: 2'd0, data: 8'h3C});
    tx_busy = 1'b0;
    cyc(1);
    chk("t4_release_start", tx_start, 1);
    req_valid = '0;

    // Reset mid-frame; the pointer returns to 0.
    cyc(2);
    chk("t5_in_frame", arb_busy, 1);
    rst = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc(1);
    chk_reset("t5_rst");
    rst = 1'b0;
    req_valid = 4'b1111;
    exp_q.push_back('{gid: 2'd0, data: 8'h10});
    exp_q.push_back('{gid: 2'd1, data: 8'h11});
    exp_q.push_back('{gid: 2'd2, data: 8'h12});
    exp_q.push_back('{gid: 2'd3, data: 8'h13});
    exp_q.push_back('{gid: 2'd0, data: 8'h10});
    wait_start("t2_first_start");
    for (int f = 0; f < 5; f++) begin
      if (f == 4) req_valid = '0;
      cyc(2);
      chk("t2_single_start", tx_start, 0);
      pulse_done();
      chk("t3_idle_entry", arb_busy, 0);
      chk("t3_no_same_cycle", tx_start, 0);
      if (f < 4) begin
        cyc(1);
        chk("t3_start_next", tx_start, 1);
      end
    end

    // Watchdog; the pointer is 1, so only requester 2 is valid.
    req_data[2*DW +: DW] = 8'h5A;
    req_valid = 4'b0100;
    exp_q.push_back('{gid: 2'd2, data: 8'h5A});
    wait_start("t6_start");
    req_valid = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      cyc(1);
      chk("t6_no_tmo_yet", timeout_err, 0);
      chk("t6_busy", arb_busy, 1);
    end
    cyc(1);
    chk("t6_tmo_pulse", timeout_err, 1);
    chk("t6_tmo_idle", arb_busy, 0);
    cyc(1);
    chk("t6_tmo_single", timeout_err, 0);
`else
    repeat (30) begin
      cyc(1);
      chk("t6_no_tmo", timeout_err, 0);
      chk("t6_stays_busy", arb_busy, 1);
    end
    pulse_done();
`endif
    req_data[0 +: DW] = 8'h77;
    req_valid = 4'b0001;
    exp_q.push_back('{gid: 2'd0, data: 8'h77});
    wait_start("t6_rearb_start");
    req_valid = '0;
    cyc(2);
    pulse_done();
    cyc(2);

    chk("sb_drained", exp_q.size(), 0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("tmo_count", tmo_seen, 1);
`else
    chk("tmo_count", tmo_seen, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
